// File: rtl/overture_cpu_p_if.sv
// I/O bundle of the Overture core: program RAM write port plus the
// valid/ready input channel and the strobed output channel.
interface overture_cpu_p_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
);
  logic              prog_we;
  logic [PC_W-1:0]   prog_addr;
  logic [7:0]        prog_data;
  logic [DATA_W-1:0] in_port;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_port;
  logic              out_valid;

  modport master (
    output prog_we, prog_addr, prog_data, in_port, in_valid,
    input  in_ready, out_port, out_valid
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, in_port, in_valid,
    output in_ready, out_port, out_valid
  );
endinterface

// File: rtl/overture_cpu_p.sv
// Parametrised single-cycle Overture core with program RAM and handshaked I/O.
// Optional single-step execution via `define OVERTURE_STEP_EN (adds the step port).
module overture_cpu_p #(
  parameter int DATA_W     = 8,
  parameter int PROG_DEPTH = 256,
  localparam int PC_W      = $clog2(PROG_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
`ifdef OVERTURE_STEP_EN
  input  logic              step,
`endif
  overture_cpu_p_if.slave   bus,
  output logic [PC_W-1:0]   pc,
  output logic [7:0]        instr_debug,
  output logic              stalled,
  output logic [DATA_W-1:0] r0_out,
  output logic [DATA_W-1:0] r1_out,
  output logic [DATA_W-1:0] r2_out,
  output logic [DATA_W-1:0] r3_out,
  output logic [DATA_W-1:0] r4_out,
  output logic [DATA_W-1:0] r5_out
);

  localparam logic [1:0] OP_IMM  = 2'd0;
  localparam logic [1:0] OP_ALU  = 2'd1;
  localparam logic [1:0] OP_COPY = 2'd2;
  localparam logic [1:0] OP_COND = 2'd3;

  logic [7:0]               mem [PROG_DEPTH];
  logic [7:0]               instr;
  logic [DATA_W-1:0]        regs [6];
  logic [DATA_W-1:0]        regs_nxt [6];
  logic [PC_W-1:0]          pc_nxt;
  logic [DATA_W-1:0]        out_port_nxt;
  logic                     out_valid_nxt;
  logic                     exec;
  logic [2:0]               src;
  logic [2:0]               dst;
  logic                     is_in_copy;
  logic [DATA_W-1:0]        src_val;
  logic signed [DATA_W-1:0] r3_s;

  function automatic logic [DATA_W-1:0] alu(input logic [2:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    case (op)
      3'd0:    return a | b;
      3'd1:    return ~(a & b);
      3'd2:    return ~(a | b);
      3'd3:    return a & b;
      3'd4:    return a + b;
      3'd5:    return a - b;
      3'd6:    return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic logic cond_met(input logic [2:0] c,
                                    input logic signed [DATA_W-1:0] v);
    logic z;
    logic n;
    z = (v == '0);
    n = v[DATA_W-1];
    case (c)
      3'd0:    return 1'b0;
      3'd1:    return z;
      3'd2:    return n;
      3'd3:    return n | z;
      3'd4:    return 1'b1;
      3'd5:    return ~z;
      3'd6:    return ~n;
      default: return ~n & ~z;
    endcase
  endfunction

  // Jump target: r0 truncated or zero-extended to the pc width.
  function automatic logic [PC_W-1:0] to_pc(input logic [DATA_W-1:0] v);
    logic [PC_W+DATA_W-1:0] w;
    w = {{PC_W{1'b0}}, v};
    return w[PC_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] imm_ext(input logic [5:0] k);
    logic [DATA_W+5:0] w;
    w = {{DATA_W{1'b0}}, k};
    return w[DATA_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
  end

  assign instr       = mem[pc];
  assign instr_debug = instr;

`ifdef OVERTURE_STEP_EN
  assign exec = run | step;
`else
  assign exec = run;
`endif

  assign src          = instr[5:3];
  assign dst          = instr[2:0];
  assign r3_s         = $signed(regs[3]);
  assign is_in_copy   = (instr[7:6] == OP_COPY) && (src == 3'd6);
  assign stalled      = run & is_in_copy & ~bus.in_valid;
  assign bus.in_ready = exec & is_in_copy & bus.in_valid & ~reset;

  always_comb begin
    src_val = '0;
    if (src == 3'd6) src_val = bus.in_port;
    for (int i = 0; i < 6; i++) begin
      if (src == 3'(i)) src_val = regs[i];
    end
  end

  always_comb begin
    regs_nxt      = regs;
    pc_nxt        = pc;
    out_port_nxt  = bus.out_port;
    out_valid_nxt = 1'b0;
    if (exec) begin
      pc_nxt = pc + 1'b1;
      case (instr[7:6])
        OP_IMM:  regs_nxt[0] = imm_ext(instr[5:0]);
        OP_ALU:  regs_nxt[3] = alu(instr[2:0], regs[1], regs[2]);
        OP_COPY: begin
          // An input copy without a word holds pc so the same instruction retries.
          if (is_in_copy && !bus.in_valid) begin
            pc_nxt = pc;
          end else if (dst == 3'd6) begin
            out_port_nxt  = src_val;
            out_valid_nxt = 1'b1;
          end else begin
            for (int i = 0; i < 6; i++) begin
              if (dst == 3'(i)) regs_nxt[i] = src_val;
            end
          end
        end
        default: begin
          if (cond_met(instr[2:0], r3_s)) pc_nxt = to_pc(regs[0]);
        end
      endcase
    end
  end

  // Architectural state update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc            <= '0;
      bus.out_port  <= '0;
      bus.out_valid <= 1'b0;
      for (int i = 0; i < 6; i++) regs[i] <= '0;
    end else begin
      pc            <= pc_nxt;
      bus.out_port  <= out_port_nxt;
      bus.out_valid <= out_valid_nxt;
      regs          <= regs_nxt;
    end
  end

  assign r0_out = regs[0];
  assign r1_out = regs[1];
  assign r2_out = regs[2];
  assign r3_out = regs[3];
  assign r4_out = regs[4];
  assign r5_out = regs[5];

endmodule

// File: tb/tb_overture_cpu_p.sv
// Directed bench for overture_cpu_p: an 8-bit/256-entry core and a
// 12-bit/16-entry core driven with hand-assembled programs.
module tb_overture_cpu_p;

  logic clk;
  logic reset;
  logic run_a;
  logic run_b;
`ifdef OVERTURE_STEP_EN
  logic step_a;
  logic step_b;
`endif

  logic [7:0]  pc_a;
  logic [7:0]  instr_a;
  logic        stalled_a;
  logic [7:0]  ra [6];
  logic [3:0]  pc_b;
  logic [7:0]  instr_b;
  logic        stalled_b;
  logic [11:0] rb [6];

  int n_cmp;
  int n_bad;

  overture_cpu_p_if #(.DATA_W(8),  .PC_W(8)) bus_a ();
  overture_cpu_p_if #(.DATA_W(12), .PC_W(4)) bus_b ();

  overture_cpu_p #(.DATA_W(8), .PROG_DEPTH(256)) dut_a (
    .clk(clk), .reset(reset), .run(run_a),
`ifdef OVERTURE_STEP_EN
    .step(step_a),
`endif
    .bus(bus_a.slave), .pc(pc_a), .instr_debug(instr_a), .stalled(stalled_a),
    .r0_out(ra[0]), .r1_out(ra[1]), .r2_out(ra[2]),
    .r3_out(ra[3]), .r4_out(ra[4]), .r5_out(ra[5])
  );

  overture_cpu_p #(.DATA_W(12), .PROG_DEPTH(16)) dut_b (
    .clk(clk), .reset(reset), .run(run_b),
`ifdef OVERTURE_STEP_EN
    .step(step_b),
`endif
    .bus(bus_b.slave), .pc(pc_b), .instr_debug(instr_b), .stalled(stalled_b),
    .r0_out(rb[0]), .r1_out(rb[1]), .r2_out(rb[2]),
    .r3_out(rb[3]), .r4_out(rb[4]), .r5_out(rb[5])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [7:0] addr, input logic [7:0] d);
    bus_a.prog_we   = 1'b1;
    bus_a.prog_addr = addr;
    bus_a.prog_data = d;
    tick();
    bus_a.prog_we   = 1'b0;
  endtask

  task automatic load_b(input logic [3:0] addr, input logic [7:0] d);
    bus_b.prog_we   = 1'b1;
    bus_b.prog_addr = addr;
    bus_b.prog_data = d;
    tick();
    bus_b.prog_we   = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    run_a = 1'b0;
    run_b = 1'b0;
`ifdef OVERTURE_STEP_EN
    step_a = 1'b0;
    step_b = 1'b0;
`endif
    bus_a.prog_we = 1'b0; bus_a.prog_addr = '0; bus_a.prog_data = '0;
    bus_a.in_port = '0;   bus_a.in_valid  = 1'b0;
    bus_b.prog_we = 1'b0; bus_b.prog_addr = '0; bus_b.prog_data = '0;
    bus_b.in_port = '0;   bus_b.in_valid  = 1'b0;

    tick();
    chk("rst_pc", pc_a, 0);
    chk("rst_r0", ra[0], 0);
    chk("rst_r5", ra[5], 0);
    chk("rst_out_port", bus_a.out_port, 0);
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_in_ready", bus_a.in_ready, 0);
    chk("rst_pc_b", pc_b, 0);
    reset = 1'b0;

    // IMM / COPY / ADD sequence
    load_a(8'h00, 8'h05);
    load_a(8'h01, 8'h81);
    load_a(8'h02, 8'h3F);
    load_a(8'h03, 8'h82);
    load_a(8'h04, 8'h44);
    chk("fetch0", instr_a, 8'h05);
    chk("idle_pc", pc_a, 0);
    run_a = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    run_a = 1'b0;
    chk("seq_r1", ra[1], 8'd5);
    chk("seq_r2", ra[2], 8'd63);
    chk("seq_r3", ra[3], 8'd68);
    chk("seq_pc", pc_a, 8'd5);
    tick();
    tick();
    chk("hold_pc", pc_a, 8'd5);
    chk("hold_r3", ra[3], 8'd68);

    // Input stall then in->out transfer
    load_a(8'h05, 8'hB6);
    chk("fetch5", instr_a, 8'hB6);
    bus_a.in_valid = 1'b0;
    run_a = 1'b1;
    #1;
    chk("stall_flag", stalled_a, 1);
    chk("stall_ready", bus_a.in_ready, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("stall_pc", pc_a, 8'd5);
    chk("stall_flag2", stalled_a, 1);
    chk("stall_ovalid", bus_a.out_valid, 0);
    bus_a.in_valid = 1'b1;
    bus_a.in_port  = 8'hA5;
    #1;
    chk("xfer_ready", bus_a.in_ready, 1);
    chk("xfer_nostall", stalled_a, 0);
    tick();
    run_a = 1'b0;
    bus_a.in_valid = 1'b0;
    chk("xfer_out", bus_a.out_port, 8'hA5);
    chk("xfer_ovalid", bus_a.out_valid, 1);
    chk("xfer_pc", pc_a, 8'd6);
    tick();
    chk("xfer_ovalid_drop", bus_a.out_valid, 0);
    chk("xfer_out_hold", bus_a.out_port, 8'hA5);

    // Conditional branches and remaining ALU ops
    load_a(8'h06, 8'hB3);
    load_a(8'h07, 8'h10);
    load_a(8'h08, 8'hC2);
    load_a(8'h10, 8'hC7);
    load_a(8'h11, 8'hC1);
    load_a(8'h12, 8'h46);
    load_a(8'h13, 8'h41);
    load_a(8'h14, 8'h45);
    load_a(8'h15, 8'h9E);
    load_a(8'h16, 8'hB9);
    load_a(8'h17, 8'h07);
    bus_a.in_valid = 1'b1;
    bus_a.in_port  = 8'h80;
    run_a = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    chk("in_r3", ra[3], 8'h80);
    chk("in_pc", pc_a, 8'h07);
    tick();
    chk("imm16", ra[0], 8'h10);
    tick();
    chk("cond_lt_taken", pc_a, 8'h10);
    tick();
    chk("cond_gt_not", pc_a, 8'h11);
    tick();
    chk("cond_eq_not", pc_a, 8'h12);
    tick();
    chk("alu_xor", ra[3], 8'h3A);
    tick();
    chk("alu_nand", ra[3], 8'hFA);
    tick();
    chk("alu_sub", ra[3], 8'hC6);
    tick();
    chk("out_r3", bus_a.out_port, 8'hC6);
    chk("out_r3_vld", bus_a.out_valid, 1);
    tick();
    chk("copy_zero", ra[1], 8'h00);
    chk("out_vld_once", bus_a.out_valid, 0);
    tick();
    chk("imm7", ra[0], 8'h07);

    // Asynchronous reset between edges, program retained
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pc", pc_a, 0);
    chk("arst_r0", ra[0], 0);
    chk("arst_r3", ra[3], 0);
    chk("arst_out", bus_a.out_port, 0);
    chk("arst_ram0", instr_a, 8'h05);
    run_a = 1'b0;
    tick();
    reset = 1'b0;
    run_a = 1'b1;
    tick();
    run_a = 1'b0;
    chk("restart_r0", ra[0], 8'd5);
    chk("restart_pc", pc_a, 8'd1);

    // 12-bit, 16-entry core: SUB underflow and pc wrap
    load_b(4'h0, 8'h01);
    load_b(4'h1, 8'h82);
    load_b(4'h2, 8'hB9);
    load_b(4'h3, 8'h45);
    load_b(4'h4, 8'h0F);
    load_b(4'h5, 8'hC4);
    load_b(4'hF, 8'h09);
    run_b = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("b_sub", rb[3], 12'hFFF);
    chk("b_pc4", pc_b, 4'd4);
    tick();
    tick();
    chk("b_jump15", pc_b, 4'd15);
    tick();
    run_b = 1'b0;
    chk("b_wrap_pc", pc_b, 4'd0);
    chk("b_wrap_r0", rb[0], 12'd9);

`ifdef OVERTURE_STEP_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      step_a = 1'b1;
      tick();
      step_a = 1'b0;
      chk("step_pc", pc_a, 32'(s));
      tick();
      tick();
      chk("step_hold", pc_a, 32'(s));
    end
    chk("step_r0", ra[0], 8'd63);
    chk("step_r1", ra[1], 8'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/overture_cpu_p.md
Name: overture_cpu_p

Overview:
- Parametrised successor to the fixed 8-bit Overture core.
- Generalises data width and program depth.
- Adds an on-chip program RAM loaded through a write port.
- Adds valid/ready input handshake with stall, plus an out_valid strobe.
- Program wrappers instantiate it, preload programs and observe the registers.

Parameters:
DATA_W, 8, register/ALU/IO width (>=6)
PROG_DEPTH, 256, program RAM entries, power of two; PC_W = clog2(PROG_DEPTH)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
run  input  1  execute one instruction per cycle when high
prog_we  input  1  program RAM write enable
prog_addr  input  PC_W  program write address
prog_data  input  8  program write data
in_port  input  DATA_W  input data
in_valid  input  1  in_port holds a word
in_ready  output  1  input word consumed this cycle
out_port  output  DATA_W  last word written to I/O
out_valid  output  1  one-cycle strobe on I/O write
pc  output  PC_W  current program counter
instr_debug  output  8  instruction at pc
stalled  output  1  high while waiting on in_valid
r0_out..r5_out  output  DATA_W  registers r0..r5 (six ports)

Behaviour:
- Reset (async):
  - pc, r0..r5, out_port = 0; out_valid, in_ready = 0.
  - Program RAM is not cleared.
- prog_we: mem[prog_addr] <= prog_data at clock edge, regardless of run; fetch sees new data next cycle.
- Fetch: combinational, instr = mem[pc]; instr_debug = instr.
- Execution: single cycle, only when run=1; when run=0, all state holds and strobes are 0.
- Decode on instr[7:6]:
  - 00 IMM: r0 <= zero-extend(instr[5:0]).
  - 01 ALU on r1, r2 -> r3; op = instr[2:0]: 0 OR, 1 NAND, 2 NOR, 3 AND, 4 ADD, 5 SUB (r1-r2), 6 XOR, 7 XNOR. Result truncated to DATA_W; no flags.
  - 10 COPY, src = instr[5:3], dst = instr[2:0]:
    - Index 0-5 = registers.
    - Index 6 = I/O.
    - Index 7: source reads 0, destination discards.
  - 11 COND: tests r3 as signed DATA_W; cond = instr[2:0]: 0 never, 1 ==0, 2 <0, 3 <=0, 4 always, 5 !=0, 6 >=0, 7 >0.
    - Taken: pc <= r0, truncated or zero-extended to PC_W.
    - Not taken: pc+1.
- pc otherwise pc+1, modulo PROG_DEPTH (wraps from PROG_DEPTH-1 to 0).
- Input handshake (COPY src=6):
  - in_valid=0: stalled=1; no register write; pc holds; in_ready=0.
  - in_valid=1: dst <= in_port; in_ready=1 for that cycle; pc advances.
  - COPY 6->6 with in_valid=1: out_port <= in_port, out_valid=1, in_ready=1.
- Output (COPY dst=6):
  - out_port <= src value; out_valid=1 for exactly the following cycle.
  - out_port holds until the next I/O write.
- stalled is combinational: run & copy & src==6 & !in_valid.
- run dropped mid-stall: stall state is implicit; execution resumes on the same instruction when run returns.
- Reset mid-program: state cleared immediately, asynchronously; execution restarts at pc=0 with the RAM contents intact.

Optional Feature:
OVERTURE_STEP_EN
- Enabled: adds input port step (1 bit).
- When run=0, a one-cycle step pulse executes exactly one instruction cycle with identical rules.
  - A stalled input copy consumes the step without advancing pc.
- step is ignored while run=1.
- Disabled: no step port; only run executes.

Test Plan:
- DATA_W=8. Load 0x05 (IMM 5), 0x81 (COPY r0->r1), 0x3F (IMM 63), 0x82 (COPY r0->r2), 0x44 (ADD); run 5 cycles -> r1=5, r2=63, r3=68, pc=5.
- Program 0xB6 (COPY in->out) with in_valid=0 for 3 cycles -> stalled=1, pc=0, in_ready=0. Then in_valid=1, in_port=0xA5 -> in_ready=1, out_port=0xA5, out_valid=1 next cycle only, pc=1.
- r3=0x80 (negative), r0=0x10, COND <0 (0xC2) -> pc=0x10. COND >0 (0xC7) -> pc+1.
- DATA_W=12, PROG_DEPTH=16, r1=0x000, r2=0x001, SUB -> r3=0xFFF. Execute at pc=15 -> pc wraps to 0.
- Assert reset mid-run after r0=7, asynchronously between edges -> all registers and pc read 0 before the next edge; RAM word 0 still reads back unchanged.
- OVERTURE_STEP_EN, run=0, three step pulses over a 3-instruction program -> pc=3; no state change between pulses.
